// File: rtl/rtc_pkg.sv
// Shared constants for the RTC read path: command byte, register map,
// strobe encodings and the bus-phase state type.
package rtc_pkg;

  localparam logic [7:0] RTC_CMD_TRANSFER = 8'hF0;
  localparam logic [7:0] ADDR_CMD         = 8'hF0;
  localparam logic [7:0] ADDR_SEG         = 8'h21;
  localparam logic [7:0] ADDR_MIN         = 8'h22;
  localparam logic [7:0] ADDR_HORA        = 8'h23;
  localparam logic [7:0] ADDR_DIA         = 8'h24;
  localparam logic [7:0] ADDR_MES         = 8'h25;
  localparam logic [7:0] ADDR_ANIO        = 8'h26;

  // {cs_n, rd_n, wr_n, a_d}
  localparam logic [3:0] CTL_IDLE      = 4'b1111;
  localparam logic [3:0] CTL_ADDR_WR   = 4'b0101;
  localparam logic [3:0] CTL_ADDR_HOLD = 4'b0111;
  localparam logic [3:0] CTL_DATA_RD   = 4'b0011;
  localparam logic [3:0] CTL_DATA_WR   = 4'b0101;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_A_SET  = 3'd1,
    PH_A_HOLD = 3'd2,
    PH_D_SET  = 3'd3,
    PH_D_END  = 3'd4,
    PH_GAP    = 3'd5
  } phase_e;

  function automatic logic [7:0] slot_addr(input logic [2:0] slot);
    logic [7:0] a;
    case (slot)
      3'd1:    a = ADDR_SEG;
      3'd2:    a = ADDR_MIN;
      3'd3:    a = ADDR_HORA;
      3'd4:    a = ADDR_DIA;
      3'd5:    a = ADDR_MES;
      3'd6:    a = ADDR_ANIO;
      default: a = ADDR_CMD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_lectura_if.sv
// Multiplexed AD bus plus RTC strobes as seen by the read sequencer (master)
// and by the pad/RTC side (slave).
interface rtc_lectura_if;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [3:0] control;

  modport master (input ad_in, output ad_out, output ad_oe, output control);
  modport slave  (output ad_in, input ad_out, input ad_oe, input control);
endinterface

// File: rtl/rtc_bus_ciclo.sv
// Runs one five-phase RTC bus cycle; chains straight into the next cycle when
// go is high on the last GAP clock so back-to-back cycles have no idle clock.
//
// state     | meaning
// PH_IDLE   | bus released, waiting for go
// PH_A_SET  | address driven, cs_n low
// PH_A_HOLD | address held, strobes settle
// PH_D_SET  | write: data driven with wr_n low / read: rd_n low, bus released
// PH_D_END  | strobes back high, write data still held
// PH_GAP    | cs_n high between cycles
module rtc_bus_ciclo
  import rtc_pkg::*;
#(
  parameter int T_PH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [3:0] control,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cap_strobe,
  output logic       fin
);

  localparam logic [5:0] CNT_LAST = 6'(T_PH - 1);

  phase_e     phase;
  logic [5:0] cnt;
  logic       last;

  assign last = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= PH_IDLE;
      cnt   <= '0;
    end else if (phase == PH_IDLE) begin
      cnt <= '0;
      if (go) phase <= PH_A_SET;
    end else if (last) begin
      cnt <= '0;
      case (phase)
        PH_A_SET:  phase <= PH_A_HOLD;
        PH_A_HOLD: phase <= PH_D_SET;
        PH_D_SET:  phase <= PH_D_END;
        PH_D_END:  phase <= PH_GAP;
        default:   phase <= go ? PH_A_SET : PH_IDLE;
      endcase
    end else begin
      cnt <= cnt + 6'd1;
    end
  end

  // rw=1 is a read; the bus is released for the whole data part of a read
  always_comb begin
    control = CTL_IDLE;
    ad_oe   = 1'b0;
    ad_out  = 8'h00;
    case (phase)
      PH_A_SET: begin
        control = CTL_ADDR_WR;
        ad_oe   = 1'b1;
        ad_out  = addr;
      end
      PH_A_HOLD: begin
        control = CTL_ADDR_HOLD;
        ad_oe   = 1'b1;
        ad_out  = addr;
      end
      PH_D_SET: begin
        if (rw) begin
          control = CTL_DATA_RD;
        end else begin
          control = CTL_DATA_WR;
          ad_oe   = 1'b1;
          ad_out  = wdata;
        end
      end
      PH_D_END: begin
        control = CTL_ADDR_HOLD;
        if (!rw) begin
          ad_oe  = 1'b1;
          ad_out = wdata;
        end
      end
      default: ;
    endcase
  end

  assign cap_strobe = (phase == PH_D_SET) && last && rw;
  assign fin        = (phase == PH_GAP) && last;

endmodule

// File: rtl/rtc_lectura.sv
// RTC read sequencer: one transfer-command write, six register reads, then an
// atomic commit of the six BCD bytes to the snapshot outputs.
//
// state  | meaning
// S_IDLE | waiting for start, bus released
// S_RUN  | slots 0..N_RD in progress (slot 0 = command write)
module rtc_lectura
  import rtc_pkg::*;
#(
  parameter int T_PH = 4,
  parameter int N_RD = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  rtc_lectura_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic [7:0]        seg,
  output logic [7:0]        min,
  output logic [7:0]        hora,
  output logic [7:0]        dia,
  output logic [7:0]        mes,
  output logic [7:0]        anio
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_RUN     = 1'b1;
  localparam logic [2:0] SLOT_LAST = 3'(N_RD);

  logic [0:0] state;
  logic [2:0] slot;
  logic [7:0] shadow [1:N_RD];

  logic       go;
  logic       cap_strobe;
  logic       fin;
  logic [3:0] control;
  logic [7:0] ad_out;
  logic       ad_oe;

  assign go = ((state == S_IDLE) && start) || (fin && (slot != SLOT_LAST));

  rtc_bus_ciclo #(.T_PH(T_PH)) u_ciclo (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .rw         (slot != 3'd0),
    .addr       (slot_addr(slot)),
    .wdata      (RTC_CMD_TRANSFER),
    .control    (control),
    .ad_out     (ad_out),
    .ad_oe      (ad_oe),
    .cap_strobe (cap_strobe),
    .fin        (fin)
  );

  assign bus.control = control;
  assign bus.ad_out  = ad_out;
  assign bus.ad_oe   = ad_oe;
  assign busy        = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      slot  <= '0;
      done  <= 1'b0;
      seg   <= 8'h00;
      min   <= 8'h00;
      hora  <= 8'h00;
      dia   <= 8'h00;
      mes   <= 8'h00;
      anio  <= 8'h00;
      for (int i = 1; i <= N_RD; i++) shadow[i] <= 8'h00;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start) state <= S_RUN;
      end else begin
        if (cap_strobe) shadow[slot] <= bus.ad_in;
        // the slot counter moves together with the bus cycle hand-over
        if (fin) begin
          if (slot == SLOT_LAST) begin
            state <= S_IDLE;
            slot  <= '0;
            done  <= 1'b1;
            seg   <= shadow[1];
            min   <= shadow[2];
            hora  <= shadow[3];
            dia   <= shadow[4];
            mes   <= shadow[5];
            anio  <= shadow[6];
          end else begin
            slot <= slot + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_lectura.sv
// Bench for rtc_lectura: T_PH=2 and T_PH=1 instances, an RTC register model on
// each bus, and a per-cycle bus trace computed from the phase schedule.
module tb_rtc_lectura;

  logic clk;
  logic rst_a, rst_b, st_a, st_b;
  logic busy_a, done_a, busy_b, done_b;
  logic [7:0] seg_a, min_a, hora_a, dia_a, mes_a, anio_a;
  logic [7:0] seg_b, min_b, hora_b, dia_b, mes_b, anio_b;

  rtc_lectura_if bus_a ();
  rtc_lectura_if bus_b ();

  rtc_lectura #(.T_PH(2)) dut_a (
    .clk(clk), .reset(rst_a), .start(st_a), .bus(bus_a.master),
    .busy(busy_a), .done(done_a),
    .seg(seg_a), .min(min_a), .hora(hora_a), .dia(dia_a), .mes(mes_a), .anio(anio_a)
  );

  rtc_lectura #(.T_PH(1)) dut_b (
    .clk(clk), .reset(rst_b), .start(st_b), .bus(bus_b.master),
    .busy(busy_b), .done(done_b),
    .seg(seg_b), .min(min_b), .hora(hora_b), .dia(dia_b), .mes(mes_b), .anio(anio_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RTC model: latches the address in the hold phase, returns data only while rd_n=0
  logic [7:0] mem [6];
  logic [7:0] lat_a, lat_b, junk;

  always @(posedge clk) begin
    junk <= 8'($urandom);
    if (bus_a.control == 4'b0111 && bus_a.ad_oe) lat_a <= bus_a.ad_out;
    if (bus_b.control == 4'b0111 && bus_b.ad_oe) lat_b <= bus_b.ad_out;
  end

  always_comb begin
    bus_a.ad_in = junk;
    if (!bus_a.control[2])
      bus_a.ad_in = (lat_a >= 8'h21 && lat_a <= 8'h26) ? mem[3'(lat_a - 8'h21)] : 8'hEE;
    bus_b.ad_in = junk;
    if (!bus_b.control[2])
      bus_b.ad_in = (lat_b >= 8'h21 && lat_b <= 8'h26) ? mem[3'(lat_b - 8'h21)] : 8'hEE;
  end

  logic        sel;
  logic [3:0]  o_ctl;
  logic        o_oe, o_busy, o_done;
  logic [7:0]  o_out;
  logic [47:0] o_snap;

  always_comb begin
    if (sel) begin
      o_ctl = bus_b.control; o_oe = bus_b.ad_oe; o_out = bus_b.ad_out;
      o_busy = busy_b; o_done = done_b;
      o_snap = {seg_b, min_b, hora_b, dia_b, mes_b, anio_b};
    end else begin
      o_ctl = bus_a.control; o_oe = bus_a.ad_oe; o_out = bus_a.ad_out;
      o_busy = busy_a; o_done = done_a;
      o_snap = {seg_a, min_a, hora_a, dia_a, mes_a, anio_a};
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [47:0] exp_snap [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (inst %0d, t=%0t): got %0h, required %0h", name, sel, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic v);
    if (sel) st_b = v; else st_a = v;
  endtask

  task automatic drive_reset(input logic v);
    if (sel) rst_b = v; else rst_a = v;
  endtask

  task automatic chk_released(input string name);
    chk({name, "_ctl"}, 64'(o_ctl), 64'(4'b1111));
    chk({name, "_oe"}, 64'(o_oe), 64'(0));
    chk({name, "_busy"}, 64'(o_busy), 64'(0));
    chk({name, "_done"}, 64'(o_done), 64'(0));
  endtask

  // Expected bus cycle i of a sequence follows from the phase schedule alone
  task automatic run_seq(input int pulse_at);
    int tph, n, slot, ph;
    logic [3:0]  ectl;
    logic        eoe;
    logic [7:0]  eout;
    logic [47:0] nsnap;
    tph   = sel ? 1 : 2;
    n     = 35 * tph;
    nsnap = {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]};
    drive_start(1'b1);
    step();
    drive_start(1'b0);
    for (int i = 0; i < n; i++) begin
      slot = i / (5 * tph);
      ph   = (i / tph) % 5;
      eoe  = 1'b0;
      eout = (slot == 0) ? 8'hF0 : 8'(8'h20 + slot);
      case (ph)
        0: begin ectl = 4'b0101; eoe = 1'b1; end
        1: begin ectl = 4'b0111; eoe = 1'b1; end
        2: begin ectl = (slot == 0) ? 4'b0101 : 4'b0011; eoe = (slot == 0); eout = 8'hF0; end
        3: begin ectl = 4'b0111; eoe = (slot == 0); eout = 8'hF0; end
        default: ectl = 4'b1111;
      endcase
      chk("ctl", 64'(o_ctl), 64'(ectl));
      chk("ad_oe", 64'(o_oe), 64'(eoe));
      if (eoe) chk("ad_out", 64'(o_out), 64'(eout));
      chk("busy", 64'(o_busy), 64'(1));
      chk("done_early", 64'(o_done), 64'(0));
      chk("snap_hold", 64'(o_snap), 64'(exp_snap[sel]));
      chk("contention", 64'(o_oe & ~o_ctl[2]), 64'(0));
      if (i == pulse_at) drive_start(1'b1);
      step();
      drive_start(1'b0);
    end
    chk("done_pulse", 64'(o_done), 64'(1));
    chk("busy_end", 64'(o_busy), 64'(0));
    chk("snapshot", 64'(o_snap), 64'(nsnap));
    exp_snap[sel] = nsnap;
    step();
    chk("done_single", 64'(o_done), 64'(0));
    for (int j = 0; j < 3; j++) begin
      chk("no_requeue", 64'(o_busy), 64'(0));
      chk("snap_stable", 64'(o_snap), 64'(exp_snap[sel]));
      step();
    end
  endtask

  typedef struct {
    logic [7:0] regs [6];
    logic       inst;
    int         pulse_at;
    logic [7:0] expect_snap [6];
  } vec_t;

  function automatic logic [7:0] rnd_bcd();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fixed0 [6];
    logic [7:0] fixed1 [6];
    logic [47:0] es;
    fixed0 = '{8'h45, 8'h30, 8'h12, 8'h07, 8'h11, 8'h24};
    fixed1 = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99};
    for (int v = 0; v < 5; v++) begin
      for (int r = 0; r < 6; r++) begin
        vecs[v].regs[r] = (v == 0) ? fixed0[r] : (v == 2) ? fixed1[r] : rnd_bcd();
        vecs[v].expect_snap[r] = vecs[v].regs[r];
      end
      vecs[v].inst     = (v == 2 || v == 3);
      vecs[v].pulse_at = (v == 0) ? 29 : (v == 3) ? 12 : -1;
    end

    sel = 1'b0; st_a = 1'b0; st_b = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    for (int r = 0; r < 6; r++) mem[r] = 8'h00;
    exp_snap[0] = '0; exp_snap[1] = '0;
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      chk_released("reset");
      chk("reset_ad_out", 64'(o_out), 64'(0));
      chk("reset_snap", 64'(o_snap), 64'(0));
    end
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (6) step();

    for (int v = 0; v < 5; v++) begin
      sel = vecs[v].inst;
      for (int r = 0; r < 6; r++) mem[r] = vecs[v].regs[r];
      run_seq(vecs[v].pulse_at);
      es = {vecs[v].expect_snap[0], vecs[v].expect_snap[1], vecs[v].expect_snap[2],
            vecs[v].expect_snap[3], vecs[v].expect_snap[4], vecs[v].expect_snap[5]};
      chk("vec_snapshot", 64'(o_snap), 64'(es));
    end

    // reset in the middle of a read sequence
    sel = 1'b0;
    for (int r = 0; r < 6; r++) mem[r] = rnd_bcd();
    drive_start(1'b1);
    step();
    drive_start(1'b0);
    repeat (39) step();
    chk("mid_busy", 64'(o_busy), 64'(1));
    drive_reset(1'b1);
    step();
    drive_reset(1'b0);
    chk_released("midrst");
    chk("midrst_snap", 64'(o_snap), 64'(0));
    exp_snap[0] = '0;
    for (int j = 0; j < 80; j++) begin
      chk("midrst_quiet_done", 64'(o_done), 64'(0));
      chk("midrst_quiet_ctl", 64'(o_ctl), 64'(4'b1111));
      step();
    end
    run_seq(-1);

    // start and reset in the same cycle
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      drive_start(1'b1);
      drive_reset(1'b1);
      step();
      drive_start(1'b0);
      drive_reset(1'b0);
      chk_released("start_rst");
      step();
      chk("start_rst_idle", 64'(o_busy), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
